// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic MAC array and its edge feeders.
package tpu_pkg;

  // Tile sequencing states of one edge feeder.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } feeder_state_t;

  // MAC input, multiply and accumulate stages.
  localparam int unsigned MAC_PIPE_DEPTH = 3;

  // Cycles of zero flush after the last operand until every accumulator is final:
  // the farthest PE sits (rows-1)+(cols-1) hops from the injection point.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return (rows - 1) + (cols - 1) + MAC_PIPE_DEPTH;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one feeder lane; reset zeroes every stage.
module skew_delay_line #(
  parameter int unsigned dataSize = 16,
  parameter int unsigned depth    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [dataSize-1:0] dataIn,
  output logic [dataSize-1:0] dataOut
);

  logic [dataSize-1:0] stage_q [depth];

  // Shift one stage per cycle; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(depth); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= dataIn;
      for (int k = 1; k < int'(depth); k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign dataOut = stage_q[depth-1];

endmodule

// File: rtl/skew_feeder.sv
// Edge feeder for the systolic MAC array: accepts operand vectors, skews lane i
// by i+1 registered cycles and sequences clear/enable/done for one tile.
module skew_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned dataSize = 16,
  parameter int unsigned rows     = 4,
  parameter int unsigned cols     = 4,
  parameter int unsigned kWidth   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [kWidth-1:0]        kLen,
  input  logic                     inValid,
  input  logic [rows*dataSize-1:0] inData,
  output logic                     inReady,
  output logic [rows*dataSize-1:0] laneOut,
  output logic                     enableOut,
  output logic                     clearOut,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DrainLen = drain_len(rows, cols);
  localparam int unsigned DrainW   = $clog2(DrainLen + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainLen - 1);

  feeder_state_t state_q, state_d;
  logic [kWidth-1:0] k_q, k_d;
  logic [kWidth-1:0] accept_q, accept_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic clear_q, clear_d;
  logic enable_q, enable_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic                     transfer;
  logic [rows*dataSize-1:0] inject;

  assign transfer = inValid & inReady;
  // Non-transfer cycles inject zeros so the accumulators hold their value.
  assign inject   = transfer ? inData : '0;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      accept_q <= '0;
      drain_q  <= '0;
      clear_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      accept_q <= accept_d;
      drain_q  <= drain_d;
      clear_q  <= clear_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    accept_d = accept_q;
    drain_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          k_d     = kLen;
        end
      end
      CLEAR: begin
        accept_d = '0;
        state_d  = (k_q != '0) ? FEED : DONE;
      end
      FEED: begin
        if (transfer) begin
          accept_d = accept_q + kWidth'(1);
          if (accept_q + kWidth'(1) == k_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q + DrainW'(1);
        if (drain_q == DrainLast) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: inReady is decoded live; the rest are registered from the next state
  // so they line up with the state they describe.
  always_comb begin
    inReady  = (state_q == FEED) && (accept_q < k_q);
    clear_d  = (state_d == CLEAR);
    enable_d = (state_d == FEED) || (state_d == DRAIN);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  assign clearOut  = clear_q;
  assign enableOut = enable_q;
  assign busy      = busy_q;
  assign done      = done_q;

  for (genvar i = 0; i < int'(rows); i++) begin : g_lane
    skew_delay_line #(
      .dataSize(dataSize),
      .depth   (i + 1)
    ) u_line (
      .clk    (clk),
      .reset  (reset),
      .dataIn (inject[i*dataSize +: dataSize]),
      .dataOut(laneOut[i*dataSize +: dataSize])
    );
  end

endmodule
